// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl - framebuffer write sequencer.
// Arbitrates the framebuffer write port between the BMP loader pixel stream
// and a solid-colour fill engine. Loader pixels are re-addressed from BMP
// bottom-up row order to top-down framebuffer order when BOTTOM_UP=1.
//
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   ld_valid/ld_ready : loader handshake (pixel taken on valid & ready)
//   ld_data, ld_sof   : RGB565 pixel and first-pixel-of-frame qualifier
//   fill_start        : one-cycle fill request, fill_color sampled on accept
//   wr_addr/data/en   : registered framebuffer write port
//   busy              : registered, high while loading or filling
//   frame_done        : pulse with the last pixel write of a frame
//   fill_done         : pulse with the last fill write
//   frame_err         : pulse when ld_sof restarts a frame mid-way
module fb_write_ctrl #(
  parameter int IMG_W     = 240,
  parameter int IMG_H     = 180,
  parameter int DEPTH     = IMG_W * IMG_H,
  parameter int BOTTOM_UP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_data,
  input  logic        ld_sof,
  input  logic        fill_start,
  input  logic [15:0] fill_color,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        frame_done,
  output logic        fill_done,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2
  } state_t;

  // Row base of the first loaded pixel and of the last one.
  localparam logic [15:0] ORIGIN    = (BOTTOM_UP != 0) ? 16'((IMG_H - 1) * IMG_W) : 16'd0;
  localparam logic [15:0] LAST_BASE = (BOTTOM_UP != 0) ? 16'd0 : 16'((IMG_H - 1) * IMG_W);
  localparam logic [15:0] ROW_STEP  = 16'(IMG_W);
  localparam logic [15:0] COL_LAST  = 16'(IMG_W - 1);
  localparam logic [15:0] ADDR_LAST = 16'(DEPTH - 1);

  state_t      state_r, state_s;
  logic [15:0] row_base_r, row_base_s;
  logic [15:0] col_r, col_s;
  logic [15:0] fill_addr_r, fill_addr_s;
  logic [15:0] fill_color_r, fill_color_s;
  logic        pending_r, pending_s;
  logic [15:0] wr_addr_r, wr_addr_s;
  logic [15:0] wr_data_r, wr_data_s;
  logic        wr_en_r, wr_en_s;
  logic        busy_r, busy_s;
  logic        frame_done_r, frame_done_s;
  logic        fill_done_r, fill_done_s;
  logic        frame_err_r, frame_err_s;

  logic        hs_s;
  logic        restart_s;
  logic [15:0] cur_base_s, cur_col_s, pix_addr_s;
  logic [15:0] adv_base_s, adv_col_s;
  logic        row_end_s, frame_end_s;

  assign ld_ready = ~rst & ((state_r == S_LOAD) | ((state_r == S_IDLE) & ~fill_start));
  assign hs_s     = ld_valid & ld_ready;

  // Pixel position: a pixel in IDLE or carrying ld_sof restarts at the origin.
  always_comb begin
    restart_s = (state_r == S_IDLE) | ld_sof;
    if (restart_s) begin
      cur_base_s = ORIGIN;
      cur_col_s  = 16'd0;
    end else begin
      cur_base_s = row_base_r;
      cur_col_s  = col_r;
    end
    pix_addr_s  = cur_base_s + cur_col_s;
    row_end_s   = (cur_col_s == COL_LAST);
    frame_end_s = row_end_s && (cur_base_s == LAST_BASE);
    if (row_end_s) begin
      adv_col_s  = 16'd0;
      adv_base_s = (BOTTOM_UP != 0) ? (cur_base_s - ROW_STEP) : (cur_base_s + ROW_STEP);
    end else begin
      adv_col_s  = cur_col_s + 16'd1;
      adv_base_s = cur_base_s;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_s      = state_r;
    row_base_s   = row_base_r;
    col_s        = col_r;
    fill_addr_s  = fill_addr_r;
    fill_color_s = fill_color_r;
    pending_s    = pending_r;
    wr_en_s      = 1'b0;
    wr_addr_s    = wr_addr_r;
    wr_data_s    = wr_data_r;
    frame_done_s = 1'b0;
    fill_done_s  = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (fill_start) begin
          fill_color_s = fill_color;
          fill_addr_s  = 16'd0;
          pending_s    = 1'b0;
          state_s      = S_FILL;
        end else if (hs_s && ld_sof) begin
          wr_en_s    = 1'b1;
          wr_addr_s  = pix_addr_s;
          wr_data_s  = ld_data;
          row_base_s = adv_base_s;
          col_s      = adv_col_s;
          state_s    = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        // A fill requested mid-frame waits; the latest colour wins.
        if (fill_start) begin
          pending_s    = 1'b1;
          fill_color_s = fill_color;
        end else begin
          pending_s = pending_r;
        end
        if (hs_s) begin
          wr_en_s     = 1'b1;
          wr_addr_s   = pix_addr_s;
          wr_data_s   = ld_data;
          frame_err_s = ld_sof;
          if (frame_end_s) begin
            frame_done_s = 1'b1;
            row_base_s   = ORIGIN;
            col_s        = 16'd0;
            if (pending_r || fill_start) begin
              pending_s   = 1'b0;
              fill_addr_s = 16'd0;
              state_s     = S_FILL;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            row_base_s = adv_base_s;
            col_s      = adv_col_s;
          end
        end else begin
          state_s = S_LOAD;
        end
      end
      S_FILL: begin
        wr_en_s   = 1'b1;
        wr_addr_s = fill_addr_r;
        wr_data_s = fill_color_r;
        if (fill_addr_r == ADDR_LAST) begin
          fill_done_s = 1'b1;
          fill_addr_s = 16'd0;
          state_s     = S_IDLE;
        end else begin
          fill_addr_s = fill_addr_r + 16'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s == S_LOAD) || (state_s == S_FILL);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      row_base_r   <= 16'd0;
      col_r        <= 16'd0;
      fill_addr_r  <= 16'd0;
      fill_color_r <= 16'd0;
      pending_r    <= 1'b0;
      wr_addr_r    <= 16'd0;
      wr_data_r    <= 16'd0;
      wr_en_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      fill_done_r  <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      row_base_r   <= row_base_s;
      col_r        <= col_s;
      fill_addr_r  <= fill_addr_s;
      fill_color_r <= fill_color_s;
      pending_r    <= pending_s;
      wr_addr_r    <= wr_addr_s;
      wr_data_r    <= wr_data_s;
      wr_en_r      <= wr_en_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      fill_done_r  <= fill_done_s;
      frame_err_r  <= frame_err_s;
    end
  end

  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign wr_en      = wr_en_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign fill_done  = fill_done_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Testbench for fb_write_ctrl. A small bottom-up instance exercises fill,
// load, resync, pending fill and reset; a full-size top-down instance runs
// one complete frame.
module tb_fb_write_ctrl;

  localparam int W  = 24;
  localparam int H  = 18;
  localparam int D  = W * H;
  localparam int TW = 240;
  localparam int TH = 180;
  localparam int TD = TW * TH;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        fd;
    logic        fl;
    logic        fe;
    logic        ct;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ld_valid, ld_ready, ld_sof, fill_start;
  logic [15:0] ld_data, fill_color, wr_addr, wr_data;
  logic        wr_en, busy, frame_done, fill_done, frame_err;

  logic        td_rst, td_ld_valid, td_ld_ready, td_ld_sof, td_fill_start;
  logic [15:0] td_ld_data, td_fill_color, td_wr_addr, td_wr_data;
  logic        td_wr_en, td_busy, td_frame_done, td_fill_done, td_frame_err;

  fb_write_ctrl #(.IMG_W(W), .IMG_H(H), .DEPTH(D), .BOTTOM_UP(1)) u_bu (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_sof(ld_sof), .fill_start(fill_start),
    .fill_color(fill_color), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .busy(busy), .frame_done(frame_done),
    .fill_done(fill_done), .frame_err(frame_err)
  );

  fb_write_ctrl #(.BOTTOM_UP(0)) u_td (
    .clk(clk), .rst(td_rst), .ld_valid(td_ld_valid), .ld_ready(td_ld_ready),
    .ld_data(td_ld_data), .ld_sof(td_ld_sof), .fill_start(td_fill_start),
    .fill_color(td_fill_color), .wr_addr(td_wr_addr), .wr_data(td_wr_data),
    .wr_en(td_wr_en), .busy(td_busy), .frame_done(td_frame_done),
    .fill_done(td_fill_done), .frame_err(td_frame_err)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_wr_cyc = 0;
  logic mon_on   = 1'b0;
  exp_t q[$];
  exp_t q_td[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bottom-up reference address: pixel p lands in row H-1-p/W, column p%W.
  function automatic logic [15:0] bu_addr(input int p);
    return 16'((H - 1 - p / W) * W + p % W);
  endfunction

  task automatic exp_push(input logic [15:0] a, input logic [15:0] d,
                          input logic fd, input logic fl, input logic fe, input logic ct);
    exp_t e;
    e.addr = a; e.data = d; e.fd = fd; e.fl = fl; e.fe = fe; e.ct = ct;
    q.push_back(e);
  endtask

  task automatic push_fill(input logic [15:0] color, input int n, input logic first_ct);
    for (int a = 0; a < n; a++)
      exp_push(16'(a), color, 1'b0, (a == D - 1), 1'b0, (a > 0) || first_ct);
  endtask

  // Offer one pixel after an optional idle gap; called at posedge+1.
  task automatic send(input logic [15:0] d, input logic sof, input logic fs,
                      input logic [15:0] fc, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    ld_valid = 1'b1; ld_data = d; ld_sof = sof; fill_start = fs; fill_color = fc;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_sof = 1'b0; fill_start = 1'b0;
  endtask

  // Send n pixels of a frame (sof on pixel 0) and queue their expected writes.
  task automatic load_frame(input logic fe0, input logic [15:0] dofs, input int n, input int gmax,
                            input int fs_a, input logic [15:0] fc_a,
                            input int fs_b, input logic [15:0] fc_b);
    logic [15:0] d;
    for (int p = 0; p < n; p++) begin
      d = 16'(p) + dofs;
      exp_push(bu_addr(p), d, (p == D - 1), 1'b0, (p == 0) && fe0, 1'b0);
      send(d, (p == 0), (p == fs_a) || (p == fs_b), (p == fs_b) ? fc_b : fc_a,
           $urandom_range(0, gmax));
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int b = 0;
    while (q.size() != 0 && b < budget) begin @(negedge clk); #1; b++; end
    check_eq(tag, q.size(), 0);
  endtask

  // Scoreboard for the bottom-up instance.
  always @(negedge clk) begin : mon_bu
    exp_t e;
    if (mon_on && !rst) begin
      if (wr_en) begin
        if (q.size() == 0) begin
          check_eq("spurious_wr_en", wr_en, 1'b0);
        end else begin
          e = q.pop_front();
          check_eq("wr_addr", wr_addr, e.addr);
          check_eq("wr_data", wr_data, e.data);
          check_eq("frame_done", frame_done, e.fd);
          check_eq("fill_done", fill_done, e.fl);
          check_eq("frame_err", frame_err, e.fe);
          if (e.ct) check_eq("back_to_back", cyc, last_wr_cyc + 1);
        end
        last_wr_cyc = cyc;
      end else begin
        check_eq("idle_pulses", {frame_done, fill_done, frame_err}, 3'b000);
      end
    end
  end

  // Scoreboard for the top-down instance.
  always @(negedge clk) begin : mon_td
    exp_t e;
    if (mon_on && !td_rst) begin
      if (td_wr_en) begin
        if (q_td.size() == 0) begin
          check_eq("td_spurious_wr_en", td_wr_en, 1'b0);
        end else begin
          e = q_td.pop_front();
          check_eq("td_wr_addr", td_wr_addr, e.addr);
          check_eq("td_wr_data", td_wr_data, e.data);
          check_eq("td_frame_done", td_frame_done, e.fd);
          check_eq("td_frame_err", td_frame_err, e.fe);
        end
      end else begin
        check_eq("td_idle_pulses", {td_frame_done, td_fill_done, td_frame_err}, 3'b000);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t et;
    int   b;
    rst = 1'b1; ld_valid = 1'b0; ld_data = 16'd0; ld_sof = 1'b0;
    fill_start = 1'b0; fill_color = 16'd0;
    td_rst = 1'b1; td_ld_valid = 1'b0; td_ld_data = 16'd0; td_ld_sof = 1'b0;
    td_fill_start = 1'b0; td_fill_color = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_flags", {wr_en, busy, frame_done, fill_done, frame_err, ld_ready}, 6'd0);
    check_eq("rst_wr_addr", wr_addr, 16'd0);
    check_eq("rst_wr_data", wr_data, 16'd0);
    check_eq("td_rst_flags", {td_wr_en, td_busy, td_frame_done, td_fill_done, td_frame_err, td_ld_ready}, 6'd0);
    rst = 1'b0; td_rst = 1'b0; mon_on = 1'b1;
    #1;
    check_eq("ready_idle", ld_ready, 1'b1);
    @(posedge clk); #1;

    // Fill from IDLE while the loader keeps offering pixels.
    fill_start = 1'b1; fill_color = 16'hF800;
    ld_valid = 1'b1; ld_sof = 1'b1; ld_data = 16'hAAAA;
    push_fill(16'hF800, D, 1'b0);
    #1;
    check_eq("ready_low_fill_req", ld_ready, 1'b0);
    @(posedge clk); #1;
    fill_start = 1'b0;
    for (int i = 0; i < D - 10; i++) begin
      if (i % 50 == 0) begin
        check_eq("ready_low_in_fill", ld_ready, 1'b0);
        check_eq("busy_in_fill", busy, 1'b1);
      end
      fill_start = (i == 20);
      fill_color = (i == 20) ? 16'h1234 : 16'hF800;
      @(posedge clk); #1;
    end
    fill_start = 1'b0; ld_valid = 1'b0; ld_sof = 1'b0;
    wait_drain("fill_drain", 100);
    @(posedge clk); #1;
    check_eq("busy_after_fill", busy, 1'b0);

    // Bottom-up frame with random valid gaps.
    load_frame(1'b0, 16'h0000, D, 2, -1, 16'h0, -1, 16'h0);
    wait_drain("load_drain", 50);
    check_eq("busy_after_load", busy, 1'b0);

    // Pixels without sof in IDLE are dropped; then a mid-frame resync.
    for (int i = 0; i < 5; i++) send(16'h5000 + 16'(i), 1'b0, 1'b0, 16'h0, 1);
    load_frame(1'b0, 16'h3000, 50, 1, -1, 16'h0, -1, 16'h0);
    check_eq("busy_mid_frame", busy, 1'b1);
    load_frame(1'b1, 16'h4000, D, 1, -1, 16'h0, -1, 16'h0);
    send(16'h6000, 1'b0, 1'b0, 16'h0, 0);
    wait_drain("resync_drain", 50);
    check_eq("busy_after_resync", busy, 1'b0);

    // Fill requested twice during a load: one fill with the later colour.
    load_frame(1'b0, 16'h2000, D, 1, 100, 16'h001F, 200, 16'h07E0);
    push_fill(16'h07E0, D, 1'b1);
    wait_drain("pending_fill_drain", D + 50);
    repeat (20) @(posedge clk);
    #1;
    check_eq("busy_after_pending_fill", busy, 1'b0);

    // Reset during a fill abandons it.
    fill_start = 1'b1; fill_color = 16'h1234;
    push_fill(16'h1234, 100, 1'b0);
    @(posedge clk); #1;
    fill_start = 1'b0;
    b = 0;
    while (q.size() != 0 && b < 500) begin @(negedge clk); #1; b++; end
    check_eq("reached_fill_100", q.size(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_kills_wr_en", wr_en, 1'b0);
    check_eq("rst_no_fill_done", fill_done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", ld_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    load_frame(1'b0, 16'h7000, D, 1, -1, 16'h0, -1, 16'h0);
    wait_drain("post_reset_drain", 50);

    // Full-size top-down frame: pixel k to address k.
    for (int k = 0; k < TD; k++) begin
      et.addr = 16'(k); et.data = 16'(k); et.fd = (k == TD - 1);
      et.fl = 1'b0; et.fe = 1'b0; et.ct = 1'b0;
      q_td.push_back(et);
      td_ld_valid = 1'b1; td_ld_data = 16'(k); td_ld_sof = (k == 0);
      @(posedge clk); #1;
    end
    td_ld_valid = 1'b0; td_ld_sof = 1'b0;
    b = 0;
    while (q_td.size() != 0 && b < 20) begin @(negedge clk); #1; b++; end
    check_eq("td_drain", q_td.size(), 0);
    check_eq("td_busy_after_frame", td_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
